fifo_rd_adapter: RTL and testbench

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

---
 rtl/fifo_rd_adapter.sv | 98 +++++++++
 tb/tb_fifo_rd_adapter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_adapter.sv
// Async-FIFO read side to valid/ready stream, via a 2-entry in-order skid buffer.
// Optional FIFO_RD_ADAPTER_STATS_EN adds a 16-bit wrapping pop_count output.
module fifo_rd_adapter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef FIFO_RD_ADAPTER_STATS_EN
  output logic [15:0]           pop_count,
`endif
  output logic [DATA_WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {OccEmpty, OccOne, OccTwo} occ_e;

  occ_e                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];

  logic       pop;
  logic       push;
  logic [1:0] occ_cnt;
  logic [1:0] occ_cnt_d;
  logic [2:0] level;

  always_comb begin
    occ_cnt    = occ_q;
    pop        = (occ_q != OccEmpty) && m_ready;
    push       = inflight_q && !flush;
    // Occupancy once the in-flight word lands and this cycle's pop leaves.
    level      = {1'b0, occ_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = rd_rst_n && !fifo_empty && !flush && (level < 3'd2);
    inflight_d = fifo_rd_en;

    occ_cnt_d  = occ_cnt + {1'b0, push} - {1'b0, pop};
    occ_d      = occ_e'(occ_cnt_d);
    head_d     = head_q ^ pop;
    tail_d     = tail_q ^ push;
    buf_d      = buf_q;
    if (push) begin
      buf_d[tail_q] = fifo_rd_data;
    end
    if (flush) begin
      occ_d  = OccEmpty;
      head_d = 1'b0;
      tail_d = 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      occ_q      <= OccEmpty;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      buf_q      <= buf_d;
    end
  end

  assign m_valid = (occ_q != OccEmpty);
  assign m_data  = buf_q[head_q];

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [15:0] pop_count_q, pop_count_d;

  // Popped words count as delivered even when flush coincides.
  always_comb begin
    pop_count_d = pop_count_q + {15'd0, pop};
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      pop_count_q <= '0;
    end else begin
      pop_count_q <= pop_count_d;
    end
  end

  assign pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Scoreboard bench for fifo_rd_adapter: behavioural FIFO with 1-cycle read latency,
// expected stream words queued at load time and compared on each accepted pop.
module tb_fifo_rd_adapter;
  localparam int unsigned DW = 32;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [15:0]   pop_count;
`endif

  fifo_rd_adapter #(.DATA_WIDTH(DW)) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .flush       (flush),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
`ifdef FIFO_RD_ADAPTER_STATS_EN
    .pop_count   (pop_count),
`endif
    .m_data      (m_data)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int            pop_cyc[$];
  int            cyc = 0;
  int            outstanding = 0;
  int            issued = 0;
  int            pops = 0;
  int            pops_since_rst = 0;
  int            look_hits = 0;
  int            first_rd = -1;
  int            first_valid = -1;
  logic          armed = 1'b0;
  logic [DW-1:0] last_pop = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    fq.push_back(w);
    sb.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Called at posedge+1 with inputs already set; samples at the negedge, then
  // advances the FIFO model just after the next rising edge.
  task automatic step();
    logic          rd_s;
    logic          pop_s;
    logic [DW-1:0] exp;
    @(negedge rd_clk);
    rd_s  = fifo_rd_en;
    pop_s = m_valid && m_ready && rd_rst_n;
    if (armed && rd_rst_n) begin
      check("no_overflow", {63'd0, (dut.occ_q == 2'd2) && dut.inflight_q}, 64'd0);
      check("rd_when_empty", {63'd0, rd_s && fifo_empty}, 64'd0);
      if (dut.occ_q == 2'd1 && dut.inflight_q && pop_s && !fifo_empty && !flush) begin
        look_hits++;
        check("lookahead_rd_en", {63'd0, fifo_rd_en}, 64'd1);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
    end
    if (rd_s) begin
      issued++;
      outstanding++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (pop_s) begin
      check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("m_data", {32'd0, m_data}, {32'd0, exp});
      end
      last_pop = m_data;
      pops++;
      pops_since_rst++;
      outstanding--;
      pop_cyc.push_back(cyc);
    end
    if (flush || !rd_rst_n) begin
      for (int i = 0; i < outstanding && sb.size() != 0; i++) void'(sb.pop_front());
      outstanding = 0;
      if (!rd_rst_n) pops_since_rst = 0;
    end
    @(posedge rd_clk);
    #1;
    cyc++;
    if (rd_s && fq.size() != 0) fifo_rd_data = fq.pop_front();
    else fifo_rd_data = 32'hDEAD_BEEF;
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    int pops0;
    logic found;
    rd_rst_n = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    step();
    step();
    rd_rst_n = 1'b1;
    armed = 1'b1;
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("rst_m_data", {32'd0, m_data}, 64'd0);

    // Basic flow
    m_ready = 1'b1;
    first_rd = -1;
    first_valid = -1;
    pop_cyc.delete();
    load(32'hA1); load(32'hA2); load(32'hA3);
    repeat (8) step();
    check("t1_latency", 64'(first_valid - first_rd), 64'd2);
    check("t1_pops", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) check("t1_consec", 64'(pop_cyc[2] - pop_cyc[0]), 64'd2);
    check("t1_drain", 64'(sb.size()), 64'd0);

    // Backpressure
    m_ready = 1'b0;
    issued = 0;
    load(32'hB0); load(32'hB1); load(32'hB2); load(32'hB3);
    repeat (5) step();
    check("t2_reads", 64'(issued), 64'd2);
    check("t2_occ", 64'(dut.occ_q), 64'd2);
    check("t2_valid", {63'd0, m_valid}, 64'd1);
    check("t2_hold", {32'd0, m_data}, 64'hB0);
    m_ready = 1'b1;
    pops0 = pops;
    repeat (8) step();
    check("t2_pops", 64'(pops - pops0), 64'd4);
    check("t2_drain", 64'(sb.size()), 64'd0);

    // Lookahead read while popping
    look_hits = 0;
    for (int i = 0; i < 6; i++) load(32'hC0 + i);
    repeat (10) step();
    check("t3_hits", {63'd0, look_hits > 0}, 64'd1);
    check("t3_drain", 64'(sb.size()), 64'd0);

    // Flush with occ=1 and a word in flight
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(32'hD0 + i);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (dut.occ_q == 2'd1 && dut.inflight_q) found = 1'b1;
    end
    check("t4_reach", {63'd0, found}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_valid", {63'd0, m_valid}, 64'd0);
    check("t4_occ", 64'(dut.occ_q), 64'd0);
    m_ready = 1'b1;
    pops0 = pops;
    for (int i = 0; i < 10 && pops == pops0; i++) step();
    check("t4_next", {32'd0, last_pop}, 64'hD2);
    repeat (6) step();
    check("t4_drain", 64'(sb.size()), 64'd0);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check("t4_pop_count", {48'd0, pop_count}, 64'(pops_since_rst[15:0]));
`endif

    // Reset mid-transfer with occ=2
    m_ready = 1'b0;
    load(32'hE0); load(32'hE1); load(32'hE2);
    repeat (4) step();
    check("t5_occ", 64'(dut.occ_q), 64'd2);
    rd_rst_n = 1'b0;
    #1;
    check("t5_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    step();
    rd_rst_n = 1'b1;
    check("t5_valid", {63'd0, m_valid}, 64'd0);
    check("t5_m_data", {32'd0, m_data}, 64'd0);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check("t5_pop_count", {48'd0, pop_count}, 64'd0);
`endif
    m_ready = 1'b1;
    repeat (5) step();
    check("t5_drain", 64'(sb.size()), 64'd0);

`ifdef FIFO_RD_ADAPTER_STATS_EN
    // Counter wrap
    rd_rst_n = 1'b0;
    step();
    rd_rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) load(i);
    for (int i = 0; i < 70000 && sb.size() != 0; i++) step();
    repeat (3) step();
    check("t6_pops", 64'(pops_since_rst), 64'd65537);
    check("t6_wrap", {48'd0, pop_count}, 64'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
